// File: rtl/ipdc_win_pkg.sv
// Shared definitions for the ipdc_win display controller: opcodes, controller
// states and the field layout of a 24-bit RGB pixel.
package ipdc_win_pkg;

    localparam int PIX_W = 24;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_RIGHT = 4'd1;
    localparam logic [3:0] OP_LEFT  = 4'd2;
    localparam logic [3:0] OP_UP    = 4'd3;
    localparam logic [3:0] OP_DOWN  = 4'd4;
    localparam logic [3:0] OP_RGB   = 4'd5;
    localparam logic [3:0] OP_GRAY  = 4'd6;
    localparam logic [3:0] OP_FLIP  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DISP = 2'd2
    } state_e;

    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;

endpackage

// File: rtl/ipdc_win_pixfmt.sv
// Combinational pixel formatter: passes RGB through, or produces the luma
// approximation Y = (R + 2G + B) >> 2 replicated on all three channels.
module ipdc_win_pixfmt
    import ipdc_win_pkg::*;
(
    input  logic [PIX_W-1:0] pix_i,
    input  logic             gray_i,
    output logic [PIX_W-1:0] pix_o
);

    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] y;

    assign r = pix_i[PIX_R_LSB +: 8];
    assign g = pix_i[PIX_G_LSB +: 8];
    assign b = pix_i[PIX_B_LSB +: 8];

    // The 10-bit sum cannot overflow (max 4*255), so bits [9:2] are exact.
    assign y = 8'(({2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b}) >> 2);

    assign pix_o = gray_i ? {y, y, y} : pix_i;

endmodule

// File: rtl/ipdc_win.sv
// Image display controller: loads an IMG_W x IMG_W image over a ready/valid
// stream, then moves/recolours/mirrors a WIN x WIN window and streams it out.
module ipdc_win
    import ipdc_win_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int WIN   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    input  logic [3:0]       i_op_mode,
    output logic             o_op_ready,
    input  logic             i_in_valid,
    input  logic [PIX_W-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [PIX_W-1:0] o_out_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int AW = 2 * CW;
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;

    localparam logic [CW-1:0] O_MAX     = CW'(IMG_W - WIN);
    localparam logic [AW-1:0] LOAD_LAST = '1;
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);

    state_e           state_q;
    logic             op_ready_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [PIX_W-1:0] out_data_q;
    logic [AW-1:0]    load_cnt_q;
    logic [WW-1:0]    wr_q;
    logic [WW-1:0]    wc_q;
    logic             disp_done_q;
    logic [CW-1:0]    orow_q;
    logic [CW-1:0]    ocol_q;
    logic             gray_q;
    logic             flip_q;

    logic [PIX_W-1:0] img_q [IMG_W*IMG_W];

    logic             load_fire;
    logic [WW-1:0]    wc_eff;
    logic [CW-1:0]    rd_row;
    logic [CW-1:0]    rd_col;
    logic [PIX_W-1:0] rd_pix;
    logic [PIX_W-1:0] fmt_pix_d;

    assign load_fire = (state_q == ST_LOAD) && i_in_valid && in_ready_q;

    // NOTE: the image store has no reset; it is pure data and resetting
    // 256 words would only cost flops. Contents are undefined until a LOAD.
    always_ff @(posedge i_clk) begin
        if (load_fire) begin
            img_q[load_cnt_q] <= i_in_data;
        end
    end

    // IMG_W is a power of two, so {row, col} is the raster address.
    assign wc_eff = flip_q ? (WIN_LAST - wc_q) : wc_q;
    assign rd_row = orow_q + CW'(wr_q);
    assign rd_col = ocol_q + CW'(wc_eff);
    assign rd_pix = img_q[{rd_row, rd_col}];

    ipdc_win_pixfmt u_pixfmt (
        .pix_i  (rd_pix),
        .gray_i (gray_q),
        .pix_o  (fmt_pix_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_ready_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            load_cnt_q  <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            disp_done_q <= 1'b0;
            orow_q      <= '0;
            ocol_q      <= '0;
            gray_q      <= 1'b0;
            flip_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    op_ready_q <= 1'b1;
                    if (i_op_valid && op_ready_q) begin
                        op_ready_q  <= 1'b0;
                        wr_q        <= '0;
                        wc_q        <= '0;
                        disp_done_q <= 1'b0;
                        state_q     <= ST_DISP;
                        case (i_op_mode)
                            OP_LOAD: begin
                                state_q    <= ST_LOAD;
                                in_ready_q <= 1'b1;
                                load_cnt_q <= '0;
                                orow_q     <= '0;
                                ocol_q     <= '0;
                            end
                            OP_RIGHT: if (ocol_q != O_MAX) ocol_q <= ocol_q + CW'(1);
                            OP_LEFT:  if (ocol_q != '0)    ocol_q <= ocol_q - CW'(1);
                            OP_UP:    if (orow_q != '0)    orow_q <= orow_q - CW'(1);
                            OP_DOWN:  if (orow_q != O_MAX) orow_q <= orow_q + CW'(1);
                            OP_RGB:   gray_q <= 1'b0;
                            OP_GRAY:  gray_q <= 1'b1;
                            OP_FLIP:  flip_q <= ~flip_q;
                            default:  state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        if (load_cnt_q == LOAD_LAST) begin
                            in_ready_q <= 1'b0;
                            op_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            load_cnt_q <= load_cnt_q + AW'(1);
                        end
                    end
                end
                ST_DISP: begin
                    // One extra cycle after the last beat drops valid and
                    // hands control back in the same edge.
                    if (disp_done_q) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        op_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= fmt_pix_d;
                        if (wc_q == WIN_LAST) begin
                            wc_q <= '0;
                            if (wr_q == WIN_LAST) begin
                                disp_done_q <= 1'b1;
                            end else begin
                                wr_q <= wr_q + WW'(1);
                            end
                        end else begin
                            wc_q <= wc_q + WW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_op_ready  = op_ready_q;
    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_ipdc_win.sv
// Directed bench for ipdc_win (IMG_W=16, WIN=4): load, moves with saturation,
// gray/RGB, flip, ignored handshakes, no-op and mid-display reset.
module tb_ipdc_win;
    import ipdc_win_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_op_valid;
    logic [3:0]  i_op_mode;
    logic        o_op_ready;
    logic        i_in_valid;
    logic [23:0] i_in_data;
    logic        o_in_ready;
    logic        o_out_valid;
    logic [23:0] o_out_data;

    int total = 0;
    int bad   = 0;

    logic [23:0] pix [256];

    ipdc_win #(.IMG_W(16), .WIN(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_op_valid  (i_op_valid),
        .i_op_mode   (i_op_mode),
        .o_op_ready  (o_op_ready),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] gray_of(input logic [23:0] p);
        logic [9:0] s;
        s = {2'b00, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b00, p[7:0]};
        return {s[9:2], s[9:2], s[9:2]};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (o_op_ready !== 1'b1 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "/op_ready"}, 24'(o_op_ready), 24'd1);
    endtask

    // Called at a negedge; returns at the negedge after the final pixel edge.
    task automatic do_load(input bit gaps, input string tag);
        int idx = 0;
        int cyc = 0;
        bit acc;
        wait_ready(tag);
        i_op_valid = 1'b1;
        i_op_mode  = OP_LOAD;
        @(negedge i_clk);
        i_op_valid = 1'b0;
        check({tag, "/in_ready_up"}, 24'(o_in_ready), 24'd1);
        check({tag, "/op_ready_down"}, 24'(o_op_ready), 24'd0);
        while (idx < 256 && cyc < 3000) begin
            i_in_data  = pix[idx];
            i_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (o_in_ready !== 1'b1) check({tag, "/in_ready_hold"}, 24'(o_in_ready), 24'd1);
            acc = i_in_valid && o_in_ready;
            @(negedge i_clk);
            if (acc) idx++;
            cyc++;
        end
        i_in_valid = 1'b0;
        check({tag, "/count"}, 24'(idx), 24'd256);
        check({tag, "/in_ready_fall"}, 24'(o_in_ready), 24'd0);
        check({tag, "/op_ready_rise"}, 24'(o_op_ready), 24'd1);
    endtask

    // Issues a display opcode and checks all WIN*WIN beats against the image
    // model; spurious op/pixel strobes mid-stream must be ignored.
    task automatic disp(input logic [3:0] mode, input int orow, input int ocol,
                        input bit flip, input bit gray, input string tag);
        logic [23:0] e;
        int r, c, cc;
        wait_ready(tag);
        i_op_valid = 1'b1;
        i_op_mode  = mode;
        @(negedge i_clk);
        i_op_valid = 1'b0;
        check({tag, "/op_ready_drop"}, 24'(o_op_ready), 24'd0);
        check({tag, "/valid_T"}, 24'(o_out_valid), 24'd0);
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                i_op_valid = 1'b1;
                i_op_mode  = OP_RIGHT;
                i_in_valid = 1'b1;
                i_in_data  = 24'hABCDEF;
            end else if (k == 3) begin
                i_op_valid = 1'b0;
                i_in_valid = 1'b0;
            end
            @(negedge i_clk);
            r  = k / 4;
            c  = k % 4;
            cc = flip ? 3 - c : c;
            e  = pix[(orow + r) * 16 + ocol + cc];
            if (gray) e = gray_of(e);
            check($sformatf("%s/valid%0d", tag, k), 24'(o_out_valid), 24'd1);
            check($sformatf("%s/data%0d", tag, k), o_out_data, e);
        end
        @(negedge i_clk);
        check({tag, "/valid_fall"}, 24'(o_out_valid), 24'd0);
        check({tag, "/data_zero"}, o_out_data, 24'd0);
        check({tag, "/op_ready_back"}, 24'(o_op_ready), 24'd1);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_op_valid = 1'b0;
        i_op_mode  = 4'd0;
        i_in_valid = 1'b0;
        i_in_data  = 24'd0;
        for (int i = 0; i < 256; i++) pix[i] = 24'(i);

        // Reset values and op_ready rising one edge after release.
        repeat (3) @(negedge i_clk);
        check("rst/op_ready", 24'(o_op_ready), 24'd0);
        check("rst/in_ready", 24'(o_in_ready), 24'd0);
        check("rst/out_valid", 24'(o_out_valid), 24'd0);
        check("rst/out_data", o_out_data, 24'd0);
        i_rst_n = 1'b1;
        #1;
        check("rel/op_ready_pre", 24'(o_op_ready), 24'd0);
        @(negedge i_clk);
        check("rel/op_ready_post", 24'(o_op_ready), 24'd1);

        // Gapped load, then move right.
        do_load(1'b1, "load1");
        disp(OP_RIGHT, 0, 1, 1'b0, 1'b0, "right");

        // Left back to (0,0), then saturate left and up.
        disp(OP_LEFT, 0, 0, 1'b0, 1'b0, "left");
        disp(OP_LEFT, 0, 0, 1'b0, 1'b0, "left_sat");
        disp(OP_UP,   0, 0, 1'b0, 1'b0, "up_sat");

        // Horizontal flip on and off.
        disp(OP_FLIP, 0, 0, 1'b1, 1'b0, "flip_on");
        disp(OP_FLIP, 0, 0, 1'b0, 1'b0, "flip_off");

        // 13 downs then 13 rights; the last of each saturates at 12.
        for (int i = 1; i <= 13; i++)
            disp(OP_DOWN, (i > 12) ? 12 : i, 0, 1'b0, 1'b0, $sformatf("down%0d", i));
        for (int i = 1; i <= 13; i++)
            disp(OP_RIGHT, 12, (i > 12) ? 12 : i, 1'b0, 1'b0, $sformatf("rt%0d", i));

        // Gray and back to RGB on a reloaded image (origin returns to 0,0).
        pix[0] = 24'h102030;
        pix[1] = 24'hFFFFFF;
        do_load(1'b0, "load2");
        disp(OP_GRAY, 0, 0, 1'b0, 1'b1, "gray");
        check("gray/p0_const", gray_of(24'h102030), 24'h202020);
        disp(OP_RGB,  0, 0, 1'b0, 1'b0, "rgb");

        // Asynchronous reset during the 5th beat.
        wait_ready("mid");
        i_op_valid = 1'b1;
        i_op_mode  = OP_RGB;
        @(negedge i_clk);
        i_op_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        check("mid/beat5_valid", 24'(o_out_valid), 24'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid/valid_rst", 24'(o_out_valid), 24'd0);
        check("mid/data_rst", o_out_data, 24'd0);
        check("mid/op_ready_rst", 24'(o_op_ready), 24'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("mid/op_ready_pre", 24'(o_op_ready), 24'd0);
        @(negedge i_clk);
        check("mid/op_ready_post", 24'(o_op_ready), 24'd1);

        // No-op: ready drops for one edge, no output.
        i_op_valid = 1'b1;
        i_op_mode  = 4'd9;
        @(negedge i_clk);
        i_op_valid = 1'b0;
        check("nop/op_ready_drop", 24'(o_op_ready), 24'd0);
        check("nop/valid0", 24'(o_out_valid), 24'd0);
        @(negedge i_clk);
        check("nop/op_ready_back", 24'(o_op_ready), 24'd1);
        check("nop/valid1", 24'(o_out_valid), 24'd0);

        // Reload and display at the origin.
        for (int i = 0; i < 256; i++) pix[i] = 24'(i);
        do_load(1'b1, "load3");
        disp(OP_RGB, 0, 0, 1'b0, 1'b0, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
